// File: rtl/register_file_if.sv
// Register file port bundle: two read ports, one write port, one debug read port.
//   master: datapath side; drives addresses and write data, receives read data.
//   slave : register file side.
interface register_file_if #(
  parameter int unsigned N = 32,
  parameter int unsigned M = 5
);
  logic [M-1:0] rd_addr_a;
  logic [M-1:0] rd_addr_b;
  logic [N-1:0] rd_data_a;
  logic [N-1:0] rd_data_b;
  logic         wr_ena;
  logic [M-1:0] wr_addr;
  logic [N-1:0] wr_data;
  logic [M-1:0] dbg_addr;
  logic [N-1:0] dbg_data;

  modport master (
    output rd_addr_a, rd_addr_b, wr_ena, wr_addr, wr_data, dbg_addr,
    input  rd_data_a, rd_data_b, dbg_data
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_ena, wr_addr, wr_data, dbg_addr,
    output rd_data_a, rd_data_b, dbg_data
  );
endinterface

// File: rtl/register_file.sv
// Architectural register file for the multicycle MIPS datapath.
// 2^M x N bits, register 0 hardwired to zero, two combinational read ports (A/B),
// one synchronous write port, and a combinational debug read port that is never bypassed.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears all registers and blocks writes
//   rf  : register_file_if slave (read A/B, write, debug read)
// BYPASS = 0 returns old contents on read-during-write; 1 forwards wr_data to A/B.
module register_file #(
  parameter int unsigned N      = 32,
  parameter int unsigned M      = 5,
  parameter int unsigned BYPASS = 0
) (
  input  logic              clk,
  input  logic              rst,
  register_file_if.slave    rf
);

  localparam int unsigned Depth = 1 << M;

  // Entry 0 has no storage; only 1..Depth-1 are flops.
  logic [N-1:0] mem_q [1:Depth-1];
  logic [N-1:0] mem_d [1:Depth-1];
  logic [N-1:0] view  [Depth];
  logic         wr_hit;

  always_comb begin
    for (int unsigned i = 1; i < Depth; i++) begin
      mem_d[i] = (rf.wr_ena && (rf.wr_addr == M'(i))) ? rf.wr_data : mem_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read view with the constant-zero entry spliced in at address 0.
  always_comb begin
    view[0] = '0;
    for (int unsigned i = 1; i < Depth; i++) begin
      view[i] = mem_q[i];
    end
  end

  // A write that will actually land; reset blocks writes, so it blocks forwarding too.
  assign wr_hit = (BYPASS != 0) && !rst && rf.wr_ena && (rf.wr_addr != '0);

  always_comb begin
    rf.rd_data_a = view[rf.rd_addr_a];
    rf.rd_data_b = view[rf.rd_addr_b];
    if (wr_hit && (rf.rd_addr_a == rf.wr_addr)) rf.rd_data_a = rf.wr_data;
    if (wr_hit && (rf.rd_addr_b == rf.wr_addr)) rf.rd_data_b = rf.wr_data;
    rf.dbg_data = view[rf.dbg_addr];
  end

endmodule
